// File: rtl/fifo_serializer.sv
// fifo_serializer
// Drain stage between the FIFO read port and a bit-serial sink. Pops one
// DATA_WIDTH-bit word at a time and shifts it out one bit per accepted beat
// on a valid/ready interface, marking the final bit and counting words.
//
// Handshake: a serial beat transfers on a rising edge where o_ser_valid and
// i_ser_ready are both high. Once o_ser_valid is raised, it and
// o_ser_data/o_ser_last stay put until that beat transfers (only reset may
// withdraw it). i_ser_ready may change freely.
//
// FIFO side: o_fifo_rd is a one-cycle pop strobe. The popped word is on
// i_fifo_data in the following cycle (the WAIT state), where it is captured.

module fifo_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_fifo_rd,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_ser_data,
    output logic                  o_ser_valid,
    input  logic                  i_ser_ready,
    output logic                  o_ser_last,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_word_count,
    output logic [1:0]            o_dbg_state
);

    // Bit index counter only has to reach DATA_WIDTH-1.
    localparam int BIT_CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no word held; pop as soon as the FIFO has one
        ST_WAIT  = 2'd1,   // pop issued last cycle; FIFO data valid now
        ST_SHIFT = 2'd2    // presenting bits of the held word
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [CNT_WIDTH-1:0]    r_word_count;
    logic                    w_valid;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_out_bit;
    logic                    w_fifo_rd;

    // Output end of the shift register and the shift direction follow MSB_FIRST.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_out_bit    = r_shift[DATA_WIDTH-1];
            assign w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    assign w_valid = (r_state == ST_SHIFT);
    assign w_xfer  = w_valid & i_ser_ready;
    assign w_last  = w_valid & (r_bit_cnt == LAST_IDX);

    // Next-state and pop strobe. A pop happens either from IDLE or on the
    // cycle the last bit of a word transfers, so words run back to back with
    // a single WAIT bubble. Reset suppresses the strobe so no word is popped
    // and then thrown away by the register reset.
    always_comb begin
        w_next_state = r_state;
        w_fifo_rd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_fifo_empty) begin
                    w_fifo_rd    = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_xfer && w_last) begin
                    if (!i_fifo_empty) begin
                        w_fifo_rd    = 1'b1;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (!i_rst_n) begin
            w_fifo_rd = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift register and bit index: load in WAIT, advance only on a transfer
    // so everything on the serial side holds under backpressure.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_shift   <= i_fifo_data;
            r_bit_cnt <= '0;
        end else if (w_xfer) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Completed-word counter; wraps silently at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_word_count <= '0;
        end else if (w_xfer && w_last) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign o_fifo_rd    = w_fifo_rd;
    assign o_ser_valid  = w_valid;
    assign o_ser_data   = w_out_bit;
    assign o_ser_last   = w_last;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_word_count = r_word_count;
    assign o_dbg_state  = r_state;

    // A pop against an empty FIFO would underflow it.
    a_no_rd_when_empty: assert property (@(posedge i_clk) !(o_fifo_rd && i_fifo_empty));

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: a 32-bit MSB-first instance and an 8-bit
// LSB-first instance with a 2-bit word counter, each fed by a small FIFO
// model. Pushing a word also queues its expected {last,bit} beats.

module tb_fifo_serializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    int n_checks = 0;
    int n_fails  = 0;
    int model_cnt32 = 0;
    int model_cnt8  = 0;

    // ---------------- 32-bit MSB-first instance ----------------
    logic        rd32, empty32, ser_data32, valid32, ready32, last32, busy32;
    logic [31:0] fifo_data32 = '0;
    logic [15:0] count32;
    logic [1:0]  st32;
    logic [31:0] mem32 [0:63];
    int          wr32 = 0;
    int          rp32 = 0;
    logic [1:0]  exp_q32[$];

    assign empty32 = (wr32 == rp32);
    always @(posedge clk) begin
        if (rd32) begin
            fifo_data32 <= mem32[rp32 % 64];
            rp32        <= rp32 + 1;
        end
    end

    fifo_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1), .CNT_WIDTH(16)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_fifo_rd(rd32), .i_fifo_empty(empty32), .i_fifo_data(fifo_data32),
        .o_ser_data(ser_data32), .o_ser_valid(valid32), .i_ser_ready(ready32),
        .o_ser_last(last32), .o_busy(busy32), .o_word_count(count32),
        .o_dbg_state(st32)
    );

    // ---------------- 8-bit LSB-first instance ----------------
    logic        rd8, empty8, ser_data8, valid8, ready8, last8, busy8;
    logic [7:0]  fifo_data8 = '0;
    logic [1:0]  count8;
    logic [1:0]  st8;
    logic [7:0]  mem8 [0:63];
    int          wr8 = 0;
    int          rp8 = 0;
    logic [1:0]  exp_q8[$];

    assign empty8 = (wr8 == rp8);
    always @(posedge clk) begin
        if (rd8) begin
            fifo_data8 <= mem8[rp8 % 64];
            rp8        <= rp8 + 1;
        end
    end

    fifo_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(2)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_fifo_rd(rd8), .i_fifo_empty(empty8), .i_fifo_data(fifo_data8),
        .o_ser_data(ser_data8), .o_ser_valid(valid8), .i_ser_ready(ready8),
        .o_ser_last(last8), .o_busy(busy8), .o_word_count(count8),
        .o_dbg_state(st8)
    );

    // ---------------- driver tasks ----------------
    task automatic push32(input logic [31:0] w);
        mem32[wr32 % 64] = w;
        wr32 = wr32 + 1;
        for (int i = 31; i >= 0; i--) exp_q32.push_back({(i == 0), w[i]});
    endtask

    task automatic push8(input logic [7:0] w);
        mem8[wr8 % 64] = w;
        wr8 = wr8 + 1;
        for (int i = 0; i < 8; i++) exp_q8.push_back({(i == 7), w[i]});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ready32 = 1'b1;
        ready8 = 1'b1;
        push32(32'hA500_0001);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (rd32 !== 1'b0 || valid32 !== 1'b0 || count32 !== 16'd0 || busy32 !== 1'b0 ||
                last32 !== 1'b0 || ser_data32 !== 1'b0) begin
                n_fails++;
                $display("FAIL reset cycle %0d: rd=%b valid=%b count=%0d busy=%b last=%b data=%b, required all 0",
                         c, rd32, valid32, count32, busy32, last32, ser_data32);
            end
        end
        model_cnt32 = 0;
    endtask

    // Reset is released at cycle 0 with 0xA5000001 already queued.
    task automatic test_single_word();
        int first_valid, last_cyc, rd_n, rd_cyc;
        logic [1:0] e;
        first_valid = -1; last_cyc = -1; rd_n = 0; rd_cyc = -1;
        for (int cyc = 0; cyc < 100 && exp_q32.size() > 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) rst_n = 1'b1;
            ready32 = 1'b1;
            #1;
            n_checks++;
            if (count32 !== model_cnt32[15:0]) begin
                n_fails++;
                $display("FAIL single count cyc %0d: got %0d want %0d", cyc, count32, model_cnt32);
            end
            if (rd32) begin rd_n++; rd_cyc = cyc; end
            if (valid32 && first_valid < 0) first_valid = cyc;
            if (valid32 && ready32) begin
                e = exp_q32.pop_front();
                n_checks++;
                if ({last32, ser_data32} !== e) begin
                    n_fails++;
                    $display("FAIL single beat cyc %0d: got last,data=%b%b want %b", cyc, last32, ser_data32, e);
                end
                if (e[1]) begin last_cyc = cyc; model_cnt32++; end
            end
        end
        n_checks++;
        if (exp_q32.size() != 0 || rd_n != 1 || rd_cyc != 0 || first_valid != 2 || last_cyc != 33) begin
            n_fails++;
            $display("FAIL single timing: left=%0d rd_n=%0d rd_cyc=%0d first_valid=%0d last=%0d want 0,1,0,2,33",
                     exp_q32.size(), rd_n, rd_cyc, first_valid, last_cyc);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (valid32 !== 1'b0 || busy32 !== 1'b0 || st32 !== 2'd0 || count32 !== 16'd1) begin
            n_fails++;
            $display("FAIL single end: valid=%b busy=%b state=%0d count=%0d want 0,0,0,1",
                     valid32, busy32, st32, count32);
        end
    endtask

    task automatic test_backpressure();
        int stall, xfers, last_cyc;
        logic prev_valid, prev_xfer;
        logic [1:0] e;
        stall = 0; xfers = 0; last_cyc = -1; prev_valid = 1'b0; prev_xfer = 1'b0;
        for (int cyc = 0; cyc < 120 && (cyc == 0 || exp_q32.size() > 0); cyc++) begin
            @(negedge clk);
            if (cyc == 0) push32(32'hA500_0001);
            ready32 = !(xfers == 2 && stall < 3);
            #1;
            if (prev_valid && !prev_xfer) begin
                n_checks++;
                if (valid32 !== 1'b1) begin
                    n_fails++;
                    $display("FAIL bp valid dropped cyc %0d: got %b want 1", cyc, valid32);
                end
            end
            if (valid32 && !ready32) begin
                stall++;
                n_checks++;
                if ({last32, ser_data32} !== exp_q32[0]) begin
                    n_fails++;
                    $display("FAIL bp hold cyc %0d: got %b%b want %b", cyc, last32, ser_data32, exp_q32[0]);
                end
            end
            if (valid32 && ready32) begin
                e = exp_q32.pop_front();
                xfers++;
                n_checks++;
                if ({last32, ser_data32} !== e) begin
                    n_fails++;
                    $display("FAIL bp beat %0d: got %b%b want %b", xfers, last32, ser_data32, e);
                end
                if (e[1]) begin last_cyc = cyc; model_cnt32++; end
            end
            prev_valid = valid32;
            prev_xfer  = valid32 && ready32;
        end
        @(negedge clk);
        ready32 = 1'b1;
        #1;
        n_checks++;
        if (xfers != 32 || stall != 3 || last_cyc != 36 || count32 !== model_cnt32[15:0] || count32 !== 16'd2) begin
            n_fails++;
            $display("FAIL bp totals: xfers=%0d stall=%0d last=%0d count=%0d want 32,3,36,2",
                     xfers, stall, last_cyc, count32);
        end
    endtask

    task automatic test_back_to_back();
        int rd_n, first_valid, last_cyc, bubbles;
        int rd_at[4];
        logic [1:0] e;
        rd_n = 0; first_valid = -1; last_cyc = -1; bubbles = 0;
        for (int i = 0; i < 4; i++) rd_at[i] = -1;
        for (int cyc = 0; cyc < 150 && (cyc == 0 || exp_q32.size() > 0); cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin push32(32'hFFFF_FFFF); push32(32'h0000_0000); end
            ready32 = 1'b1;
            #1;
            n_checks++;
            if (rd32 && empty32) begin
                n_fails++;
                $display("FAIL b2b rd while empty cyc %0d: got rd=1 want 0", cyc);
            end
            if (rd32) begin
                if (rd_n < 4) rd_at[rd_n] = cyc;
                rd_n++;
            end
            if (valid32 && first_valid < 0) first_valid = cyc;
            if (!valid32 && first_valid >= 0) bubbles++;
            if (valid32) begin
                e = exp_q32.pop_front();
                n_checks++;
                if ({last32, ser_data32} !== e) begin
                    n_fails++;
                    $display("FAIL b2b beat cyc %0d: got %b%b want %b", cyc, last32, ser_data32, e);
                end
                if (e[1]) begin last_cyc = cyc; model_cnt32++; end
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_n != 2 || rd_at[0] != 0 || rd_at[1] != 33 || bubbles != 1 || first_valid != 2 ||
            last_cyc != 66 || count32 !== 16'd4) begin
            n_fails++;
            $display("FAIL b2b timing: rd_n=%0d rd@%0d,%0d bubbles=%0d first=%0d last=%0d count=%0d want 2,0,33,1,2,66,4",
                     rd_n, rd_at[0], rd_at[1], bubbles, first_valid, last_cyc, count32);
        end
    endtask

    task automatic test_reset_mid_word();
        int xfers, first_valid, last_cyc, rd_n;
        logic [1:0] e;
        xfers = 0;
        for (int cyc = 0; cyc < 40 && xfers < 10; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin push32(32'h1234_5678); push32(32'hCAFE_F00D); end
            ready32 = 1'b1;
            #1;
            if (valid32) begin
                e = exp_q32.pop_front();
                xfers++;
                n_checks++;
                if ({last32, ser_data32} !== e) begin
                    n_fails++;
                    $display("FAIL midrst beat %0d: got %b%b want %b", xfers, last32, ser_data32, e);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd32 !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst rd in reset: got %b want 0", rd32);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (valid32 !== 1'b0 || count32 !== 16'd0 || busy32 !== 1'b0 || rd32 !== 1'b0) begin
                n_fails++;
                $display("FAIL midrst held %0d: valid=%b count=%0d busy=%b rd=%b want 0,0,0,0",
                         c, valid32, count32, busy32, rd32);
            end
        end
        while (exp_q32.size() > 32) void'(exp_q32.pop_front());
        model_cnt32 = 0;
        first_valid = -1; last_cyc = -1; rd_n = 0;
        for (int cyc = 0; cyc < 100 && exp_q32.size() > 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) rst_n = 1'b1;
            #1;
            if (rd32) rd_n++;
            if (valid32 && first_valid < 0) first_valid = cyc;
            if (valid32) begin
                e = exp_q32.pop_front();
                n_checks++;
                if ({last32, ser_data32} !== e) begin
                    n_fails++;
                    $display("FAIL midrst resume cyc %0d: got %b%b want %b", cyc, last32, ser_data32, e);
                end
                if (e[1]) begin last_cyc = cyc; model_cnt32++; end
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_n != 1 || first_valid != 2 || last_cyc != 33 || count32 !== 16'd1 || exp_q32.size() != 0) begin
            n_fails++;
            $display("FAIL midrst resume: rd_n=%0d first=%0d last=%0d count=%0d left=%0d want 1,2,33,1,0",
                     rd_n, first_valid, last_cyc, count32, exp_q32.size());
        end
    endtask

    task automatic test_random_stall();
        logic prev_valid, prev_xfer;
        logic [1:0] e;
        prev_valid = 1'b0; prev_xfer = 1'b0;
        for (int cyc = 0; cyc < 600 && (cyc == 0 || exp_q32.size() > 0); cyc++) begin
            @(negedge clk);
            if (cyc == 0) for (int k = 0; k < 3; k++) push32($urandom);
            ready32 = ($urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if (count32 !== model_cnt32[15:0]) begin
                n_fails++;
                $display("FAIL rand count cyc %0d: got %0d want %0d", cyc, count32, model_cnt32);
            end
            if (prev_valid && !prev_xfer && valid32 !== 1'b1) begin
                n_fails++;
                $display("FAIL rand valid dropped cyc %0d: got %b want 1", cyc, valid32);
            end
            if (valid32 && ready32) begin
                e = exp_q32.pop_front();
                n_checks++;
                if ({last32, ser_data32} !== e) begin
                    n_fails++;
                    $display("FAIL rand beat cyc %0d: got %b%b want %b", cyc, last32, ser_data32, e);
                end
                if (e[1]) model_cnt32++;
            end
            prev_valid = valid32;
            prev_xfer  = valid32 && ready32;
        end
        @(negedge clk);
        ready32 = 1'b1;
        #1;
        n_checks++;
        if (exp_q32.size() != 0 || count32 !== 16'd4 || valid32 !== 1'b0) begin
            n_fails++;
            $display("FAIL rand end: left=%0d count=%0d valid=%b want 0,4,0", exp_q32.size(), count32, valid32);
        end
    endtask

    task automatic test_lsb_first_wrap();
        logic [1:0] e;
        for (int cyc = 0; cyc < 400 && (cyc == 0 || exp_q8.size() > 0); cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                push8(8'h01); push8(8'h80); push8(8'h5A); push8(8'hC3); push8(8'hFF);
            end
            ready8 = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (count8 !== model_cnt8[1:0]) begin
                n_fails++;
                $display("FAIL w8 count cyc %0d: got %0d want %0d", cyc, count8, model_cnt8[1:0]);
            end
            if (valid8 && ready8) begin
                e = exp_q8.pop_front();
                n_checks++;
                if ({last8, ser_data8} !== e) begin
                    n_fails++;
                    $display("FAIL w8 beat cyc %0d: got %b%b want %b", cyc, last8, ser_data8, e);
                end
                if (e[1]) model_cnt8++;
            end
        end
        @(negedge clk);
        ready8 = 1'b1;
        #1;
        n_checks++;
        if (exp_q8.size() != 0 || count8 !== 2'd1 || busy8 !== 1'b0) begin
            n_fails++;
            $display("FAIL w8 end: left=%0d count=%0d busy=%b want 0,1,0", exp_q8.size(), count8, busy8);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n   = 1'b0;
        ready32 = 1'b1;
        ready8  = 1'b1;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random_stall();
        test_lsb_first_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
